// File: rtl/anpc_gate_monitor_if.sv
// Gate-monitor bus: the six ANPC gate signals and timing limits going in,
// decoded level, commutation timing and fault flags coming out.
//   master : side that drives the gate bus and limits (FSM / bench)
//   slave  : the monitor itself
interface anpc_gate_monitor_if #(
    parameter int TDELAY_WIDTH = 16
);
    logic [5:0]              S_in;
    logic [TDELAY_WIDTH-1:0] t_dead_min;
    logic [TDELAY_WIDTH-1:0] t_trans_max;
    logic                    fault_clr;
    logic [1:0]              v_lev_out;
    logic                    v_valid;
    logic [TDELAY_WIDTH-1:0] trans_cycles;
    logic                    trans_done;
    logic                    fault;
    logic [2:0]              fault_code;

    modport master (
        output S_in, t_dead_min, t_trans_max, fault_clr,
        input  v_lev_out, v_valid, trans_cycles, trans_done, fault, fault_code
    );

    modport slave (
        input  S_in, t_dead_min, t_trans_max, fault_clr,
        output v_lev_out, v_valid, trans_cycles, trans_done, fault, fault_code
    );
endinterface

// File: rtl/anpc_gate_monitor.sv
// anpc_gate_monitor: passive observer of the 3L-ANPC gate bus.
// Registers the gate bus, decodes it into P/N/O levels, measures commutation
// length, and raises sticky shoot-through / dead-time / timeout faults.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   mon  - anpc_gate_monitor_if.slave (S_in, t_dead_min, t_trans_max,
//          fault_clr in; v_lev_out, v_valid, trans_cycles, trans_done,
//          fault, fault_code out)

// Dead-time checker for one complementary pair (a, b).
// Ports: clk, rst, current/previous state of both switches, minimum
// dead-time, and a single-cycle violation flag.
module anpc_deadtime_chk #(
    parameter int TDELAY_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    a_i,
    input  logic                    b_i,
    input  logic                    a_prev_i,
    input  logic                    b_prev_i,
    input  logic [TDELAY_WIDTH-1:0] t_dead_min_i,
    output logic                    viol_o
);
    typedef enum logic [1:0] {LAST_NONE = 2'd0, LAST_A = 2'd1, LAST_B = 2'd2} last_e;

    last_e                   last_q, last_d;
    logic [TDELAY_WIDTH-1:0] off_cnt_q, off_cnt_d;
    logic                    rise_a, rise_b;

    always_comb begin
        rise_a = a_i & ~a_prev_i;
        rise_b = b_i & ~b_prev_i;
        // Only a hand-over from the opposite switch can violate dead-time;
        // off_cnt_q is 0 on a direct swap because the other switch was on.
        viol_o = (t_dead_min_i != '0) && (off_cnt_q < t_dead_min_i) &&
                 ((rise_a && last_q == LAST_B) || (rise_b && last_q == LAST_A));

        // Both-on leaves the owner unchanged; shoot-through is flagged elsewhere.
        last_d = last_q;
        if (a_i && !b_i)
            last_d = LAST_A;
        else if (b_i && !a_i)
            last_d = LAST_B;

        if (a_i || b_i)
            off_cnt_d = '0;
        else if (&off_cnt_q)
            off_cnt_d = off_cnt_q;
        else
            off_cnt_d = off_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q    <= LAST_NONE;
            off_cnt_q <= '0;
        end else begin
            last_q    <= last_d;
            off_cnt_q <= off_cnt_d;
        end
    end
endmodule

module anpc_gate_monitor #(
    parameter int TDELAY_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    anpc_gate_monitor_if.slave   mon
);
    typedef enum logic [1:0] {ST_UNKNOWN = 2'd0, ST_STEADY = 2'd1, ST_TRANSIT = 2'd2} state_e;

    state_e                  state_q, state_d;
    logic [5:0]              s_q, s_prev_q;
    logic [TDELAY_WIDTH-1:0] cnt_q, cnt_d;
    logic [TDELAY_WIDTH-1:0] tcyc_q, tcyc_d;
    logic [1:0]              lev_q, lev_d;
    logic                    valid_q, valid_d;
    logic                    done_q, done_d;
    logic [2:0]              fcode_q, fcode_d;

    logic                    is_p, is_n, is_o, pat_valid, timeout, shoot;
    logic [1:0]              pat_lev;
    logic [2:0]              pa, pb, pa_prev, pb_prev, dt_viol;

    // Pattern decode (s_q[0..5] = S1..S6)
    always_comb begin
        is_p      = s_q[0] & s_q[1] & ~s_q[2] & ~s_q[3];
        is_n      = s_q[2] & s_q[3] & ~s_q[0] & ~s_q[1];
        is_o      = ~s_q[0] & ~s_q[3] &
                    ((s_q[1] & s_q[4] & ~s_q[2]) | (s_q[2] & s_q[5] & ~s_q[1]));
        pat_valid = is_p | is_n | is_o;
        pat_lev   = is_p ? 2'b01 : (is_n ? 2'b10 : 2'b00);
    end

    // Complementary pairs: (S1,S5), (S2,S3), (S4,S6)
    assign pa      = {s_q[3], s_q[1], s_q[0]};
    assign pb      = {s_q[5], s_q[2], s_q[4]};
    assign pa_prev = {s_prev_q[3], s_prev_q[1], s_prev_q[0]};
    assign pb_prev = {s_prev_q[5], s_prev_q[2], s_prev_q[4]};
    assign shoot   = |(pa & pb);

    for (genvar g = 0; g < 3; g++) begin : g_dt
        anpc_deadtime_chk #(.TDELAY_WIDTH(TDELAY_WIDTH)) u_chk (
            .clk          (clk),
            .rst          (rst),
            .a_i          (pa[g]),
            .b_i          (pb[g]),
            .a_prev_i     (pa_prev[g]),
            .b_prev_i     (pb_prev[g]),
            .t_dead_min_i (mon.t_dead_min),
            .viol_o       (dt_viol[g])
        );
    end

    // Decode FSM: next state and registered outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lev_d   = lev_q;
        valid_d = valid_q;
        tcyc_d  = tcyc_q;
        done_d  = 1'b0;
        timeout = 1'b0;
        case (state_q)
            ST_UNKNOWN: begin
                if (pat_valid) begin
                    state_d = ST_STEADY;
                    lev_d   = pat_lev;
                    valid_d = 1'b1;
                end
            end
            ST_STEADY: begin
                if (pat_valid) begin
                    if (pat_lev != lev_q) begin
                        lev_d  = pat_lev;
                        done_d = 1'b1;
                        tcyc_d = '0;
                    end
                end else begin
                    state_d = ST_TRANSIT;
                    cnt_d   = {{(TDELAY_WIDTH-1){1'b0}}, 1'b1};
                    valid_d = 1'b0;
                end
            end
            ST_TRANSIT: begin
                if (pat_valid) begin
                    state_d = ST_STEADY;
                    lev_d   = pat_lev;
                    valid_d = 1'b1;
                    tcyc_d  = cnt_q;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                    // cnt_q already counts the transitional cycles before this
                    // one, so a commutation of exactly t_trans_max cycles passes.
                    timeout = (mon.t_trans_max != '0) && (cnt_q >= mon.t_trans_max);
                end
            end
            default: state_d = ST_UNKNOWN;
        endcase

        // Set wins over clear
        fcode_d = (mon.fault_clr ? 3'b000 : fcode_q) | {timeout, |dt_viol, shoot};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q      <= '0;
            s_prev_q <= '0;
            state_q  <= ST_UNKNOWN;
            cnt_q    <= '0;
            lev_q    <= 2'b00;
            valid_q  <= 1'b0;
            tcyc_q   <= '0;
            done_q   <= 1'b0;
            fcode_q  <= 3'b000;
        end else begin
            s_q      <= mon.S_in;
            s_prev_q <= s_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lev_q    <= lev_d;
            valid_q  <= valid_d;
            tcyc_q   <= tcyc_d;
            done_q   <= done_d;
            fcode_q  <= fcode_d;
        end
    end

    assign mon.v_lev_out    = lev_q;
    assign mon.v_valid      = valid_q;
    assign mon.trans_cycles = tcyc_q;
    assign mon.trans_done   = done_q;
    assign mon.fault_code   = fcode_q;
    assign mon.fault        = |fcode_q;
endmodule
